pipe_memory: RTL and testbench

Memory stage of the 5-stage Y86-64 pipeline. It consumes the M pipeline register produced by pipe_execute (M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM) and performs the data-memory read or write. It generates m_stat and m_valM for forwarding and hazard control, and drives the W pipeline register into writeback.
Data memory is an internal byte array, 64-bit little-endian access.

---
 rtl/pipe_memory.sv | 105 ++++++++++
 tb/tb_pipe_memory.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_memory.sv
// Memory stage of the Y86-64 pipeline: data-memory access, m_stat/m_valM forwarding, W register.
// Optional PIPE_MEM_ALIGN_CHECK_EN flags any access whose address is not 8-byte aligned as ADR.
module pipe_memory #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]       mem [MEM_BYTES];
  logic             mem_read;
  logic             mem_write;
  logic [63:0]      mem_addr;
  logic [IDX_W-1:0] idx;
  logic             range_err;
  logic             align_err;
  logic             dmem_error;
  logic             mem_we;

  assign mem_read  = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) || (M_icode == I_RET);
  assign mem_write = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
  assign mem_addr  = ((M_icode == I_POPQ) || (M_icode == I_RET)) ? M_valA : M_valE;
  assign idx       = mem_addr[IDX_W-1:0];

  // The last legal start address leaves room for all 8 bytes; nothing wraps.
  assign range_err = (mem_read || mem_write) && (mem_addr[ADDR_W-1:0] > ADDR_LAST);

`ifdef PIPE_MEM_ALIGN_CHECK_EN
  assign align_err = (mem_read || mem_write) && (mem_addr[2:0] != 3'b000);
`else
  assign align_err = 1'b0;
`endif

  assign dmem_error = range_err || align_err;
  assign m_stat     = dmem_error ? STAT_ADR : M_stat;
  assign mem_we     = mem_write && !dmem_error && (M_stat == STAT_AOK) && !rst;

  always_comb begin
    m_valM = '0;
    if (mem_read && !dmem_error) begin
      for (int i = 0; i < 8; i++) begin
        m_valM[8*i +: 8] = mem[idx + IDX_W'(i)];
      end
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + IDX_W'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= RNONE;
      W_dstM  <= RNONE;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: tb/tb_pipe_memory.sv
// Self-checking bench for pipe_memory: directed scenarios then randomized traffic vs a byte-array model.
module tb_pipe_memory;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic        W_stall, W_bubble;
  logic [3:0]  m_stat, W_stat, W_icode, W_dstE, W_dstM;
  logic [63:0] m_valM, W_valE, W_valM;

  pipe_memory #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic [63:0] e_valE, e_valM;
  logic [63:0] last_valM;
  logic [3:0]  last_mstat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    return v;
  endfunction

  // One pipeline cycle: drive M, check m_* before the edge, check W after it.
  task automatic step(input logic [3:0] stat, input logic [3:0] icode,
                      input logic [63:0] valE, input logic [63:0] valA,
                      input logic [3:0] dstE, input logic [3:0] dstM,
                      input logic stall, input logic bubble, input logic r);
    logic        rd, wr, err;
    logic [63:0] a, x_valM;
    logic [3:0]  x_stat;
    M_stat = stat; M_icode = icode; M_valE = valE; M_valA = valA;
    M_dstE = dstE; M_dstM = dstM; W_stall = stall; W_bubble = bubble; rst = r;
    #1;
    rd  = (icode == 4'h5) || (icode == 4'hB) || (icode == 4'h9);
    wr  = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
    a   = ((icode == 4'hB) || (icode == 4'h9)) ? valA : valE;
    err = (rd || wr) && (a > 64'(MEM_BYTES - 8));
`ifdef PIPE_MEM_ALIGN_CHECK_EN
    if ((rd || wr) && (a % 8 != 0)) err = 1'b1;
`endif
    x_stat = err ? 4'h3 : stat;
    x_valM = (rd && !err) ? ref_rd(a) : 64'h0;
    check("m_stat", 64'(m_stat), 64'(x_stat));
    check("m_valM", m_valM, x_valM);
    last_valM  = m_valM;
    last_mstat = m_stat;
    @(posedge clk);
    #1;
    if (wr && !err && stat == 4'h1 && !r)
      for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = valA[8*i +: 8];
    if (r || bubble) begin
      e_stat = 4'h1; e_icode = 4'h1; e_valE = 0; e_valM = 0; e_dstE = 4'hF; e_dstM = 4'hF;
    end else if (!stall) begin
      e_stat = x_stat; e_icode = icode; e_valE = valE; e_valM = x_valM; e_dstE = dstE; e_dstM = dstM;
    end
    check("W_stat",  64'(W_stat),  64'(e_stat));
    check("W_icode", 64'(W_icode), 64'(e_icode));
    check("W_valE",  W_valE, e_valE);
    check("W_valM",  W_valM, e_valM);
    check("W_dstE",  64'(W_dstE),  64'(e_dstE));
    check("W_dstM",  64'(W_dstM),  64'(e_dstM));
  endtask

  initial begin
    logic [3:0]  ops [10];
    logic [3:0]  op, st;
    logic [63:0] addr, other;
    ops = '{4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h7};
    rst = 1'b1; W_stall = 0; W_bubble = 0;
    M_stat = 4'h1; M_icode = 4'h1; M_valE = 0; M_valA = 0; M_dstE = 4'hF; M_dstM = 4'hF;
    @(posedge clk);
    #1;

    // Reset for two cycles
    step(4'h1, 4'h1, 0, 0, 4'hF, 4'hF, 0, 0, 1);
    step(4'h1, 4'h1, 0, 0, 4'hF, 4'hF, 0, 0, 1);
    check("rst_W_icode", 64'(W_icode), 64'h1);
    check("rst_W_dstM",  64'(W_dstM),  64'hF);

    // Fill the whole memory so every later read is defined
    for (int k = 0; k < MEM_BYTES / 8; k++)
      step(4'h1, 4'h4, 64'(8 * k), {$urandom, $urandom}, 4'hF, 4'hF, 0, 0, 0);

    // Store then load at 16
    step(4'h1, 4'h4, 16, 64'h1122334455667788, 4'hF, 4'hF, 0, 0, 0);
    step(4'h1, 4'h5, 16, 0, 4'hF, 4'h2, 0, 0, 0);
    check("load16", last_valM, 64'h1122334455667788);
    check("byte16", 64'(last_valM[7:0]), 64'h88);
    check("W_icode_ld", 64'(W_icode), 64'h5);

    // Pop addressing uses valA
    step(4'h1, 4'h4, 24, 64'd99, 4'hF, 4'hF, 0, 0, 0);
    step(4'h1, 4'hB, 32, 24, 4'h4, 4'h4, 0, 0, 0);
    check("pop_valM", last_valM, 64'd99);

    // Out-of-range store, verify untouched, then last legal slot
    step(4'h1, 4'h4, 1020, 5, 4'hF, 4'hF, 0, 0, 0);
    check("adr_mstat", 64'(last_mstat), 64'h3);
    step(4'h1, 4'h5, 1016, 0, 4'hF, 4'h1, 0, 0, 0);
    step(4'h1, 4'h4, 1016, 5, 4'hF, 4'hF, 0, 0, 0);
    check("edge_mstat", 64'(last_mstat), 64'h1);
    step(4'h1, 4'h5, 1016, 0, 4'hF, 4'h1, 0, 0, 0);
    check("edge_load", last_valM, 64'd5);

    // Stall holds, bubble beats stall
    step(4'h1, 4'h6, 30, 0, 4'h2, 4'hF, 0, 0, 0);
    step(4'h1, 4'h5, 8, 0, 4'hF, 4'h3, 1, 0, 0);
    step(4'h1, 4'h5, 8, 0, 4'hF, 4'h3, 1, 0, 0);
    check("stall_valE", W_valE, 64'd30);
    step(4'h1, 4'h5, 8, 0, 4'hF, 4'h3, 1, 1, 0);

    // Exception status suppresses the store
    step(4'h4, 4'hA, 40, 7, 4'h4, 4'hF, 0, 0, 0);
    step(4'h1, 4'h5, 40, 0, 4'hF, 4'h1, 0, 0, 0);
    step(4'h2, 4'h5, 40, 0, 4'hF, 4'h1, 0, 0, 0);

    // Store during reset is dropped
    step(4'h1, 4'h4, 48, 64'hDEAD_BEEF, 4'hF, 4'hF, 0, 0, 1);
    step(4'h1, 4'h5, 48, 0, 4'hF, 4'h1, 0, 0, 0);

    // Misaligned and huge addresses
    step(4'h1, 4'h5, 17, 0, 4'hF, 4'h1, 0, 0, 0);
    step(4'h1, 4'h9, 0, 64'h8000_0000_0000_0000, 4'hF, 4'hF, 0, 0, 0);

    // Randomized traffic
    repeat (400) begin
      op = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: addr = 64'(8 * $urandom_range(0, MEM_BYTES / 8 - 1));
        6, 7:             addr = 64'($urandom_range(0, MEM_BYTES - 1));
        8:                addr = 64'(MEM_BYTES - 8 + $urandom_range(0, 15));
        default:          addr = {$urandom, $urandom};
      endcase
      other = {$urandom, $urandom};
      st = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h2 : 4'h4) : 4'h1;
      if (op == 4'hB || op == 4'h9)
        step(st, op, other, addr, 4'($urandom), 4'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      else
        step(st, op, addr, other, 4'($urandom), 4'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
